// File: rtl/t03_display_pkg.sv
// Shared display-path definitions for team 03: colour type, transparency key
// and default active-area geometry.
package t03_display_pkg;

  localparam int COLOR_W = 8;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COLLISION_W = 19;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t TRANSPARENT_KEY = 8'h00;
  localparam logic [COLLISION_W-1:0] COLLISION_MAX = 19'h7FFFF;

endpackage

// File: rtl/t03_priority_select.sv
// Combinational layer priority mux: lowest-index opaque layer wins, otherwise
// the background colour; also flags pixels where two or more layers are opaque.
module t03_priority_select
  import t03_display_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  color_t                        bg_color,
  output color_t                        sel_color,
  output logic                          multi_opaque
);

  logic [NUM_LAYERS-1:0] opaque;
  logic                  found;

  // Walk from layer 0 upward so the first opaque hit keeps the selection
  always_comb begin
    sel_color    = bg_color;
    multi_opaque = 1'b0;
    found        = 1'b0;
    opaque       = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_valid[i] && (layer_color[i*COLOR_W +: COLOR_W] != TRANSPARENT_KEY);
      if (opaque[i]) begin
        if (!found) begin
          sel_color = layer_color[i*COLOR_W +: COLOR_W];
        end
        multi_opaque = multi_opaque | found;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t03_layer_compositor.sv
// Final pixel stage: aligns layers to a 2-cycle pipeline, picks the top opaque
// layer or the frame-synchronous background. Optional collision counter: T03_COLLISION_CNT_EN.
module t03_layer_compositor
  import t03_display_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [10:0]                   Hcnt,
  input  logic [10:0]                   Vcnt,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic                          bg_color_wr,
  input  logic [7:0]                    bg_color_data,
  output logic [7:0]                    pixel_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          de_out,
  output logic                          frame_start,
  output logic [18:0]                   collision_count
);

  logic                  first_in;
  logic                  active_in;
  logic [NUM_LAYERS-1:0] valid_a;
  logic                  hsync_a;
  logic                  vsync_a;
  logic                  active_a;
  logic                  first_a;
  color_t                bg_pending;
  color_t                bg_active;
  logic                  synced;
  color_t                sel_color;
  logic                  multi_opaque;
  color_t                pixel_next;

  assign first_in  = (Hcnt == 11'd0) && (Vcnt == 11'd0);
  assign active_in = (Hcnt < 11'(H_ACTIVE)) && (Vcnt < 11'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a  <= '0;
      hsync_a  <= 1'b1;
      vsync_a  <= 1'b1;
      active_a <= 1'b0;
      first_a  <= 1'b0;
    end else begin
      valid_a  <= layer_valid;
      hsync_a  <= hsync_in;
      vsync_a  <= vsync_in;
      active_a <= active_in;
      first_a  <= first_in;
    end
  end

  // bg_active swaps as pixel (0,0) enters stage A, so the whole frame shares one background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_pending <= TRANSPARENT_KEY;
      bg_active  <= TRANSPARENT_KEY;
    end else begin
      if (bg_color_wr) begin
        bg_pending <= bg_color_data;
      end
      if (first_in) begin
        bg_active <= bg_color_wr ? bg_color_data : bg_pending;
      end
    end
  end

  // Output stays blank after reset until a full frame boundary has been seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced <= 1'b0;
    end else if (first_a) begin
      synced <= 1'b1;
    end
  end

  t03_priority_select #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_priority_select (
    .layer_valid (valid_a),
    .layer_color (layer_color),
    .bg_color    (bg_active),
    .sel_color   (sel_color),
    .multi_opaque(multi_opaque)
  );

  always_comb begin
    pixel_next = TRANSPARENT_KEY;
    if (active_a && (synced || first_a)) begin
      pixel_next = sel_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= TRANSPARENT_KEY;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_out   <= pixel_next;
      hsync_out   <= hsync_a;
      vsync_out   <= vsync_a;
      de_out      <= active_a;
      frame_start <= first_a;
    end
  end

`ifdef T03_COLLISION_CNT_EN
  logic                   collide;
  logic [COLLISION_W-1:0] run_count;
  logic [COLLISION_W-1:0] count_reg;

  assign collide = active_a && multi_opaque;

  // The pixel (0,0) collision belongs to the new frame, hence the restart at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count <= '0;
      count_reg <= '0;
    end else if (first_a) begin
      count_reg <= run_count;
      run_count <= collide ? 19'd1 : 19'd0;
    end else if (collide && (run_count != COLLISION_MAX)) begin
      run_count <= run_count + 19'd1;
    end
  end

  assign collision_count = count_reg;
`else
  logic unused_multi_opaque;
  assign unused_multi_opaque = multi_opaque;
  assign collision_count     = '0;
`endif

endmodule
